qed_mem_reader: RTL

Sequential read-side engine for the QED instruction memory. Once started, it streams `count_i` consecutive words out of a synchronous-read RAM port, beginning at `base_addr_i`. Each word is presented as an instruction on a valid/ready interface, which feeds the QED module's `ifu_qed_instruction` input or a checker. It is the counterpart of `qed_mem_shim`: the shim writes instruction words into the RAM, and this block reads them back. A 2-entry buffer absorbs the 1-cycle RAM read latency, so the block never drops or duplicates a word under backpressure.

---
 rtl/qed_mem_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/qed_mem_reader.sv
// Streams a burst of consecutive words from a synchronous-read RAM onto a
// valid/ready instruction port, using a 2-entry buffer to absorb read latency.
module qed_mem_reader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_vld_o,
  input  logic              instr_rdy_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [ADDR_W:0]     issue_left;
  logic [ADDR_W:0]     pop_left;
  logic                inflight;
  logic [DATA_W-1:0]   fifo_mem [2];
  logic                wr_idx;
  logic                rd_idx;
  logic [1:0]          fifo_cnt;
  logic                done_q;

  logic                pop;
  logic                push;
  logic                issue;
  logic                credit_ok;
  logic                start_go;
  logic                last_pop;
  logic [1:0]          occupancy;

  assign instr_vld_o = (fifo_cnt != 2'd0);
  assign instr_o     = fifo_mem[rd_idx];
  assign mem_addr_o  = rd_ptr;
  assign mem_rd_en_o = issue;
  assign busy_o      = (state != IDLE);
  assign done_o      = done_q;

  // A word counts against the 2-entry buffer from the cycle it is issued,
  // so a new read is only allowed if its data is guaranteed a free slot.
  always_comb begin
    pop       = instr_vld_o && instr_rdy_i;
    push      = inflight;
    occupancy = fifo_cnt + {1'b0, inflight};
    credit_ok = ((occupancy - {1'b0, pop}) < 2'd2);
    issue     = (state == READ) && (issue_left != '0) && credit_ok;
    start_go  = (state == IDLE) && start_i;
    last_pop  = (state == DRAIN) && pop && (pop_left == (ADDR_W+1)'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_i && (count_i != '0)) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (issue && (issue_left == (ADDR_W+1)'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst bookkeeping: captured on start, then advanced by issues and pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      issue_left <= '0;
      pop_left   <= '0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight <= issue;
      done_q   <= (start_go && (count_i == '0)) || last_pop;
      if (start_go) begin
        rd_ptr     <= base_addr_i;
        issue_left <= count_i;
        pop_left   <= count_i;
      end else begin
        if (issue) begin
          issue_left <= issue_left - (ADDR_W+1)'(1);
          if (rd_ptr == ADDR_W'(DEPTH - 1)) begin
            rd_ptr <= '0;
          end else begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
          end
        end
        if (pop) begin
          pop_left <= pop_left - (ADDR_W+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_idx] <= mem_data_i;
        wr_idx           <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
